// File: rtl/i2s_transmit_24.sv
// I2S (Philips) serial transmitter: accepts stereo sample pairs over valid/ready
// and shifts them MSB-first onto sd_o, one SCK after each WS edge.
module i2s_transmit_24 #(
    parameter int DATA_WIDTH = 24,
    parameter int SLOT_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  sck_i,
    input  logic                  ws_i,
    input  logic [DATA_WIDTH-1:0] left_i,
    input  logic [DATA_WIDTH-1:0] right_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic                  sd_o,
    output logic                  frame_start_o,
    output logic                  underrun_o,
    output logic [15:0]           underrun_count_o
);

    localparam int PAIR_W = 2 * DATA_WIDTH;
    localparam int CNT_W  = $clog2(SLOT_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_WIDTH);

    logic                  sck_q, sck_d;
    logic                  ws_last_q, ws_last_d;
    logic                  synced_q, synced_d;
    logic                  hold_full_q, hold_full_d;
    logic [PAIR_W-1:0]     hold_q, hold_d;
    logic [PAIR_W-1:0]     active_q, active_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  sd_q, sd_d;
    logic                  frame_start_q, frame_start_d;
    logic                  underrun_q, underrun_d;
    logic [15:0]           ucnt_q, ucnt_d;

    logic fe_s, ws_fall_s, ws_rise_s;

    assign fe_s      = sck_q & ~sck_i;
    assign ws_fall_s = fe_s & ws_last_q & ~ws_i;
    assign ws_rise_s = fe_s & ~ws_last_q & ws_i;

    assign ready_o          = ~hold_full_q;
    assign sd_o             = sd_q;
    assign frame_start_o    = frame_start_q;
    assign underrun_o       = underrun_q;
    assign underrun_count_o = ucnt_q;

    // Holding register: filled by the handshake, drained by every frame load
    always_comb begin
        if (ws_fall_s) begin
            hold_d      = hold_q;
            hold_full_d = 1'b0;
        end else if (valid_i && !hold_full_q) begin
            hold_d      = {left_i, right_i};
            hold_full_d = 1'b1;
        end else begin
            hold_d      = hold_q;
            hold_full_d = hold_full_q;
        end
    end

    // Frame load, slot reload and serial shifting, all qualified by SCK falling events
    always_comb begin
        sck_d         = sck_i;
        synced_d      = synced_q;
        active_d      = active_q;
        shift_d       = shift_q;
        bit_cnt_d     = bit_cnt_q;
        sd_d          = sd_q;
        frame_start_d = 1'b0;
        underrun_d    = 1'b0;
        ucnt_d        = ucnt_q;

        if (fe_s) begin
            ws_last_d = ws_i;
        end else begin
            ws_last_d = ws_last_q;
        end

        if (ws_fall_s) begin
            synced_d      = 1'b1;
            frame_start_d = 1'b1;
            if (hold_full_q) begin
                active_d = hold_q;
            end else if (valid_i) begin
                // Empty holding register: the offered pair goes straight on air
                active_d = {left_i, right_i};
            end else begin
                active_d   = {PAIR_W{1'b0}};
                underrun_d = 1'b1;
                if (ucnt_q != 16'hFFFF) begin
                    ucnt_d = ucnt_q + 16'd1;
                end else begin
                    ucnt_d = ucnt_q;
                end
            end
            shift_d   = active_d[PAIR_W-1:DATA_WIDTH];
            bit_cnt_d = {CNT_W{1'b0}};
        end else if (ws_rise_s && synced_q) begin
            shift_d   = active_q[DATA_WIDTH-1:0];
            bit_cnt_d = {CNT_W{1'b0}};
        end else if (fe_s && synced_q) begin
            if (bit_cnt_q < CNT_MAX) begin
                sd_d      = shift_q[DATA_WIDTH-1];
                shift_d   = {shift_q[DATA_WIDTH-2:0], 1'b0};
                bit_cnt_d = bit_cnt_q + CNT_W'(1'b1);
            end else begin
                sd_d      = 1'b0;
                bit_cnt_d = CNT_MAX;
            end
        end else begin
            shift_d = shift_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sck_q         <= 1'b0;
            ws_last_q     <= 1'b0;
            synced_q      <= 1'b0;
            hold_full_q   <= 1'b0;
            hold_q        <= {PAIR_W{1'b0}};
            active_q      <= {PAIR_W{1'b0}};
            shift_q       <= {DATA_WIDTH{1'b0}};
            bit_cnt_q     <= {CNT_W{1'b0}};
            sd_q          <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
            ucnt_q        <= 16'd0;
        end else begin
            sck_q         <= sck_d;
            ws_last_q     <= ws_last_d;
            synced_q      <= synced_d;
            hold_full_q   <= hold_full_d;
            hold_q        <= hold_d;
            active_q      <= active_d;
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            sd_q          <= sd_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
            ucnt_q        <= ucnt_d;
        end
    end

endmodule

// File: tb/tb_i2s_transmit_24.sv
// Bench for i2s_transmit_24: drives an SCK/WS generator, decodes sd_o like a
// receiver would, and compares against a queue-based frame model.
module tb_i2s_transmit_24;
    localparam int DW = 24;

    logic          clk, rst, sck, ws, valid, ready, sd, fs, ur;
    logic [DW-1:0] left, right;
    logic [15:0]   ucnt;

    int checks = 0;
    int errors = 0;

    i2s_transmit_24 #(.DATA_WIDTH(DW), .SLOT_WIDTH(32)) dut (
        .clk_i(clk), .rst_i(rst), .sck_i(sck), .ws_i(ws),
        .left_i(left), .right_i(right), .valid_i(valid),
        .ready_o(ready), .sd_o(sd), .frame_start_o(fs),
        .underrun_o(ur), .underrun_count_o(ucnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // SCK = 4 clk periods, 64 SCK per frame; WS toggles with the SCK fall
    logic gen_en;
    int   ph = 0;
    int   sck_idx = 40;
    initial begin
        sck = 1'b0;
        ws  = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (gen_en) begin
                ph = (ph + 1) % 4;
                if (ph == 0) begin
                    sck_idx = (sck_idx + 1) % 64;
                    sck = 1'b0;
                    ws  = (sck_idx >= 32);
                end else if (ph == 2) begin
                    sck = 1'b1;
                end
            end
        end
    end

    // Reference model and serial decoder
    logic [47:0]   exp_q[$];
    logic [47:0]   m_hold = 48'd0;
    logic [47:0]   last_frame = 48'd0;
    logic [DW-1:0] l_acc = '0, r_acc = '0;
    logic          m_sck_q = 1'b0, m_ws_last = 1'b0, m_synced = 1'b0, m_hold_full = 1'b0;
    logic          exp_fs = 1'b0, exp_ur = 1'b0, dec_prev_sck = 1'b0;
    logic [15:0]   m_ucnt = 16'd0;
    int            wsf_total = 0;

    always @(negedge clk) begin
        logic        fe, wsf;
        logic [47:0] f;
        int          p;
        chk("ready_o", 48'(ready), 48'(!m_hold_full));
        chk("frame_start_o", 48'(fs), 48'(exp_fs));
        chk("underrun_o", 48'(ur), 48'(exp_ur));
        chk("underrun_count_o", 48'(ucnt), 48'(m_ucnt));

        if (sck && !dec_prev_sck) begin
            p = sck_idx % 32;
            if (!m_synced || p == 0 || p > DW) begin
                chk("sd_pad", 48'(sd), 48'd0);
            end else if (sck_idx < 32) begin
                l_acc = {l_acc[DW-2:0], sd};
            end else begin
                r_acc = {r_acc[DW-2:0], sd};
            end
            if (sck_idx == 63 && exp_q.size() > 0) begin
                f = exp_q.pop_front();
                last_frame = {l_acc, r_acc};
                chk("frame", last_frame, f);
            end
        end
        dec_prev_sck = sck;

        if (rst) begin
            m_sck_q = 1'b0; m_ws_last = 1'b0; m_synced = 1'b0; m_hold_full = 1'b0;
            m_ucnt = 16'd0; exp_fs = 1'b0; exp_ur = 1'b0;
            exp_q.delete();
        end else begin
            fe  = m_sck_q && !sck;
            wsf = fe && m_ws_last && !ws;
            exp_fs = 1'b0;
            exp_ur = 1'b0;
            if (wsf) begin
                m_synced = 1'b1;
                exp_fs = 1'b1;
                wsf_total++;
                if (m_hold_full) begin
                    exp_q.push_back(m_hold);
                    m_hold_full = 1'b0;
                end else if (valid) begin
                    exp_q.push_back({left, right});
                end else begin
                    exp_q.push_back(48'd0);
                    exp_ur = 1'b1;
                    if (m_ucnt != 16'hFFFF) m_ucnt++;
                end
            end else if (valid && !m_hold_full) begin
                m_hold = {left, right};
                m_hold_full = 1'b1;
            end
            if (fe) m_ws_last = ws;
            m_sck_q = sck;
        end
    end

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic wait_frames(input int n);
        int target;
        int cyc;
        target = wsf_total + n;
        cyc = 0;
        while (wsf_total < target && cyc < n * 300) begin
            tick();
            cyc++;
        end
        chk("frame_wait", 48'(wsf_total), 48'(target));
    endtask

    task automatic send_pair(input logic [DW-1:0] l, input logic [DW-1:0] r);
        int cyc;
        cyc = 0;
        left = l; right = r; valid = 1'b1;
        @(negedge clk);
        while (!ready && cyc < 600) begin
            @(negedge clk);
            cyc++;
        end
        chk("accept_wait", 48'(ready), 48'd1);
        tick();
    endtask

    initial begin
        logic [DW-1:0] l, r;
        int            cyc;
        rst = 1'b1; valid = 1'b0; left = '0; right = '0; gen_en = 1'b0;
        repeat (3) tick();
        chk("rst_sd", 48'(sd), 48'd0);
        chk("rst_ready", 48'(ready), 48'd1);
        chk("rst_fs", 48'(fs), 48'd0);
        chk("rst_ur", 48'(ur), 48'd0);
        chk("rst_ucnt", 48'(ucnt), 48'd0);

        rst = 1'b0; gen_en = 1'b1;
        wait_frames(3);
        chk("ucnt_idle", 48'(ucnt), 48'd3);

        send_pair(24'hA5A5A5, 24'h123456);
        valid = 1'b0;
        wait_frames(2);
        chk("frame_a5", last_frame, {24'hA5A5A5, 24'h123456});
        chk("ucnt_a5", 48'(ucnt), 48'd4);

        send_pair(24'h7FFFFF, 24'h800000);
        send_pair(24'h000001, 24'hFFFFFF);
        for (int i = 0; i < 6; i++) begin
            l = 24'($urandom());
            r = 24'($urandom());
            send_pair(l, r);
        end
        chk("ucnt_stream", 48'(ucnt), 48'd4);
        valid = 1'b0;
        wait_frames(2);
        chk("frame_stream_last", last_frame, {l, r});
        chk("ucnt_after_stream", 48'(ucnt), 48'd5);

        l = 24'($urandom());
        r = 24'($urandom());
        cyc = 0;
        while (!(ph == 0 && sck_idx == 0) && cyc < 600) begin
            tick();
            cyc++;
        end
        chk("bypass_align", 48'(cyc < 600), 48'd1);
        left = l; right = r; valid = 1'b1;
        tick();
        valid = 1'b0;
        chk("bypass_fs", 48'(fs), 48'd1);
        chk("bypass_ur", 48'(ur), 48'd0);
        chk("bypass_ready", 48'(ready), 48'd1);
        chk("bypass_ucnt", 48'(ucnt), 48'd5);
        wait_frames(1);
        chk("frame_bypass", last_frame, {l, r});
        chk("ucnt_after_bypass", 48'(ucnt), 48'd6);

        cyc = 0;
        while (sck_idx != 8 && cyc < 600) begin
            tick();
            cyc++;
        end
        rst = 1'b1;
        tick();
        chk("midrst_sd", 48'(sd), 48'd0);
        chk("midrst_ucnt", 48'(ucnt), 48'd0);
        chk("midrst_ready", 48'(ready), 48'd1);
        repeat (512) tick();
        rst = 1'b0;
        l = 24'($urandom());
        r = 24'($urandom());
        send_pair(l, r);
        valid = 1'b0;
        wait_frames(2);
        chk("frame_after_reset", last_frame, {l, r});
        chk("ucnt_after_reset", 48'(ucnt), 48'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
